// File: rtl/popcount_frame_sequencer_pkg.sv
// popcount_frame_sequencer_pkg
//   Shared definitions for the popcount frame sequencer: datapath widths,
//   FSM state encoding and the frame-length clamp helper.
package popcount_frame_sequencer_pkg;

   localparam int WORD_W    = 32;                          // fixed: population_counter width
   localparam int MAX_WORDS = 16;                          // longest frame in words
   localparam int LEN_W     = $clog2(MAX_WORDS + 1);       // 5
   localparam int TOT_W     = $clog2(WORD_W * MAX_WORDS + 1); // 10, holds 512
   localparam int CNT_W     = $clog2(WORD_W + 1);          // 6, per-word count

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Requested lengths above MAX_WORDS are served as MAX_WORDS, which also
   // bounds the accumulator so it can never overflow TOT_W bits.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      return (l > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : l;
   endfunction

endpackage

// File: rtl/popcount_frame_sequencer_population_counter.sv
// population_counter
//   Combinational population count of one data word.
//   Ports:
//     a  in  WORD_W  data word
//     Q  out CNT_W   number of set bits in a
module population_counter
   import popcount_frame_sequencer_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   output logic [CNT_W-1:0]  Q
);

   always_comb begin
      Q = '0;
      for (int i = 0; i < WORD_W; i++) begin
         Q = Q + CNT_W'(a[i]);
      end
   end

endmodule

// File: rtl/popcount_frame_sequencer.sv
// popcount_frame_sequencer
//   Runs population_counter over a frame of 1..MAX_WORDS words arriving on a
//   valid/ready stream, accumulates the per-word counts and offers the frame
//   total on a valid/ready output port.
//   Ports:
//     clk        in   1       clock, rising edge
//     rst        in   1       synchronous active-high reset, overrides everything
//     start      in   1       begin a frame (only looked at in IDLE)
//     len        in   LEN_W   frame length in words, captured with start
//     abort      in   1       drop the current frame (RUN or DONE)
//     in_data    in   WORD_W  input word
//     in_valid   in   1       in_data valid
//     in_ready   out  1       word accepted this cycle if in_valid
//     out_total  out  TOT_W   frame popcount total
//     out_valid  out  1       out_total valid
//     out_ready  in   1       consumer takes out_total
//     busy       out  1       FSM not in IDLE
//     dbg_state  out  state_t current FSM state, for observation only
//
//   Handshake semantics: a transfer happens on a rising edge where both valid
//   and ready are high. in_ready and out_valid come straight from registers, so
//   neither depends combinationally on in_valid or out_ready. While out_valid is
//   high, out_total is held until the transfer happens.
module popcount_frame_sequencer
   import popcount_frame_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   input  logic               abort,
   input  logic [WORD_W-1:0]  in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [TOT_W-1:0]   out_total,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy,
   output state_t             dbg_state
);

   state_t             r_state;
   logic [LEN_W-1:0]   r_len_q;
   logic [LEN_W-1:0]   r_cnt;
   logic [TOT_W-1:0]   r_acc;
   logic [TOT_W-1:0]   r_out_total;
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;

   logic [CNT_W-1:0]   w_q;
   logic [TOT_W-1:0]   w_sum;
   logic               w_accept;
   logic               w_last;

   population_counter u_popcnt (
      .a (in_data),
      .Q (w_q)
   );

   assign w_sum    = r_acc + TOT_W'(w_q);
   assign w_accept = in_valid & r_in_ready;
   // r_len_q is at least 1 whenever RUN is entered, so the subtraction never wraps.
   assign w_last   = (r_cnt == r_len_q - LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_len_q     <= '0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_out_total <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // start beats abort in IDLE: abort is simply not looked at here.
               if (start) begin
                  r_len_q <= clamp_len(len);
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  if (len == '0) begin
                     r_state     <= ST_DONE;
                     r_out_total <= '0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state    <= ST_RUN;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // abort wins over a word offered in the same cycle.
               if (abort) begin
                  r_state    <= ST_IDLE;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b0;
                  r_acc      <= '0;
                  r_cnt      <= '0;
               end else if (w_accept) begin
                  r_acc <= w_sum;
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (w_last) begin
                     r_state     <= ST_DONE;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_out_total <= w_sum;
                  end
               end
            end
            ST_DONE: begin
               if (abort || out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_acc       <= '0;
                  r_cnt       <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_total = r_out_total;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_popcount_frame_sequencer.sv
// tb_popcount_frame_sequencer
//   Directed and randomized frames against a reference model that sums the
//   set bits of the first min(len, MAX_WORDS) words of each frame.
module tb_popcount_frame_sequencer;
   import popcount_frame_sequencer_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [TOT_W-1:0]  out_total;
   logic              out_valid;
   logic              out_ready;
   logic              busy;
   state_t            dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [TOT_W-1:0] exp_q[$];
   logic [31:0]      wq[$];

   popcount_frame_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_total (out_total),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      start     = 1'b0;
      abort     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
   endtask

   task automatic random_inputs();
      start     = 1'($urandom_range(0, 1));
      abort     = 1'($urandom_range(0, 1));
      len       = LEN_W'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_busy"},      32'(busy),      32'd0);
      chk({tag, "_out_total"}, 32'(out_total), 32'd0);
   endtask

   // ---------------- reference model ----------------
   function automatic int model_total(input logic [31:0] w[$], input int l);
      int n;
      int sum;
      n   = (l > MAX_WORDS) ? MAX_WORDS : l;
      sum = 0;
      for (int i = 0; i < n; i++) sum += $countones(w[i]);
      return sum;
   endfunction

   // ---------------- driver ----------------
   // One whole frame: start (optionally with abort in the same cycle), feed
   // words with random gaps, hold the result for 'hold' cycles, then take it.
   task automatic run_frame(input logic [31:0] w[$], input int l, input int gap_max,
                            input int hold, input bit poke, input bit abort_with_start);
      int n;
      int accepted;
      int budget;
      logic [TOT_W-1:0] exp;
      n        = (l > MAX_WORDS) ? MAX_WORDS : l;
      accepted = 0;
      budget   = 0;
      exp_q.push_back(TOT_W'(model_total(w, l)));

      start = 1'b1;
      abort = abort_with_start;
      len   = LEN_W'(l);
      step();
      start = 1'b0;
      abort = 1'b0;
      len   = LEN_W'($urandom);
      chk("busy_after_start", 32'(busy), 32'd1);

      while (accepted < n && budget < 1000) begin
         chk("in_ready_run", 32'(in_ready), 32'd1);
         chk("out_valid_run", 32'(out_valid), 32'd0);
         in_valid = ($urandom_range(0, gap_max) == 0);
         in_data  = in_valid ? w[accepted] : $urandom;
         if (poke) begin
            start = 1'($urandom_range(0, 1));
            len   = LEN_W'($urandom);
         end
         step();
         if (in_valid) accepted++;
         budget++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      if (budget >= 1000) chk("frame_budget", 32'(budget), 32'(n));

      exp = exp_q.pop_front();
      chk("out_valid_done", 32'(out_valid), 32'd1);
      chk("in_ready_done",  32'(in_ready),  32'd0);
      chk("out_total",      32'(out_total), 32'(exp));

      // Words offered during DONE must not be absorbed.
      for (int i = 0; i < hold; i++) begin
         in_valid  = 1'b1;
         in_data   = $urandom;
         out_ready = 1'b0;
         step();
         chk("out_valid_hold", 32'(out_valid), 32'd1);
         chk("out_total_hold", 32'(out_total), 32'(exp));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_taken", 32'(out_valid), 32'd0);
      chk("busy_taken",      32'(busy),      32'd0);
      chk("state_taken",     32'(dbg_state), 32'(ST_IDLE));
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      // Reset held two cycles under random inputs.
      rst = 1'b1;
      random_inputs();
      step();
      check_reset_outputs("rst_cycle1");
      random_inputs();
      step();
      check_reset_outputs("rst_cycle2");
      rst = 1'b0;
      idle_inputs();
      step();
      check_reset_outputs("post_rst_idle");

      // Three back-to-back words, result held 3 cycles: 32 + 4 + 0 = 36.
      wq = '{32'hFFFF_FFFF, 32'h0000_000F, 32'h0000_0000};
      run_frame(wq, 3, 0, 3, 1'b0, 1'b0);

      // Zero-length frame.
      wq.delete();
      run_frame(wq, 0, 0, 2, 1'b0, 1'b0);

      // Full frame of all-ones with gaps: 512.
      wq.delete();
      for (int i = 0; i < 16; i++) wq.push_back(32'hFFFF_FFFF);
      run_frame(wq, 16, 2, 1, 1'b0, 1'b0);

      // Over-long request clamped to 16 words.
      wq.delete();
      for (int i = 0; i < 20; i++) wq.push_back($urandom);
      run_frame(wq, 20, 1, 3, 1'b0, 1'b0);

      // Abort after two accepts; the word offered with abort is dropped.
      start = 1'b1;
      len   = LEN_W'(4);
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      step();
      step();
      abort   = 1'b1;
      in_data = 32'h1234_5678;
      step();
      abort    = 1'b0;
      in_valid = 1'b0;
      chk("abort_busy",      32'(busy),      32'd0);
      chk("abort_in_ready",  32'(in_ready),  32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      wq = '{32'h0000_0001};
      run_frame(wq, 1, 0, 0, 1'b0, 1'b0);

      // Abort while DONE.
      start = 1'b1;
      len   = '0;
      step();
      start = 1'b0;
      chk("done_zero_valid", 32'(out_valid), 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("done_abort_valid", 32'(out_valid), 32'd0);
      chk("done_abort_busy",  32'(busy),      32'd0);

      // abort together with start in IDLE: the frame still starts.
      wq = '{32'h0000_00FF, 32'h0000_0003};
      run_frame(wq, 2, 0, 1, 1'b0, 1'b1);

      // start pulses during RUN are ignored.
      wq = '{$urandom, $urandom, $urandom};
      run_frame(wq, 3, 1, 1, 1'b1, 1'b0);

      // Reset in the middle of a frame.
      start = 1'b1;
      len   = LEN_W'(8);
      step();
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = $urandom;
         step();
      end
      rst = 1'b1;
      random_inputs();
      step();
      check_reset_outputs("mid_run_rst");
      rst = 1'b0;
      idle_inputs();
      step();
      chk("mid_run_rst_state", 32'(dbg_state), 32'(ST_IDLE));

      // Randomized frames.
      for (int f = 0; f < 12; f++) begin
         int l;
         l = $urandom_range(0, 31);
         wq.delete();
         for (int i = 0; i < 31; i++) wq.push_back($urandom);
         run_frame(wq, l, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
